// File: rtl/serial_operand_serializer_pkg.sv
// Shared definitions for the serial-compare transmit path.
// - state_t   : FSM state encoding. The comparator bench reuses it.
// - DEFAULT_WIDTH : default operand width.
// - cnt_width : bit-counter width for a given operand width.
package serial_operand_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The counter must hold WIDTH-1. A width of 1 still needs one flop.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_operand_serializer_if.sv
// Bus between the operand source and the serializer.
// Handshake: the source raises start with op_a/op_b valid. The pair is
// accepted on a rising clk edge where start=1 and ready=1. When ready=0,
// start is ignored and nothing is captured.
// The outputs (cmp_clear, a_out, b_out, bit_valid, last, done) feed the
// serial comparator and are all registered.
//   master : the operand source (drives start/op_a/op_b)
//   slave  : the serializer
interface serial_operand_serializer_if
  import serial_operand_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             cmp_clear;
  logic             a_out;
  logic             b_out;
  logic             bit_valid;
  logic             last;
  logic             done;

  modport master (
    output start, op_a, op_b,
    input  ready, cmp_clear, a_out, b_out, bit_valid, last, done
  );

  modport slave (
    input  start, op_a, op_b,
    output ready, cmp_clear, a_out, b_out, bit_valid, last, done
  );
endinterface

// File: rtl/serial_operand_serializer_piso.sv
// piso_shift_reg: WIDTH-bit parallel-in serial-out register.
// Ports:
//   clk, reset : clock and async active-high reset (clears to 0)
//   load       : capture d (load takes priority over shift)
//   shift      : shift left by one bit, zero fill
//   d          : parallel input
//   q          : current register contents (MSB is the serial bit)
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q << 1;
    end
  end
endmodule

// File: rtl/serial_operand_serializer.sv
// serial_operand_serializer: loads two operands in parallel and pulses a
// clear to the serial comparator. It then streams both operands MSB-first,
// one bit per clock, and pulses done after the last bit.
// Ports:
//   clk, reset : clock and async active-high reset
//   bus        : serializer side of serial_operand_serializer_if
//   dbg_state  : current FSM state, for observation only
module serial_operand_serializer
  import serial_operand_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  serial_operand_serializer_if.slave   bus,
  output state_t                       dbg_state
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0] sa_shl, sb_shl;
  logic             take, shift_en;
  logic             ready_q, clear_q, a_q, b_q, valid_q, last_q, done_q;

  // start counts only while ready is high (IDLE and DONE).
  assign take     = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign shift_en = (state == ST_SHIFT);

  // These are the register contents after this edge's shift. Their MSB is
  // the bit that is shown next.
  assign sa_shl = sa << 1;
  assign sb_shl = sb << 1;

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk(clk), .reset(reset), .load(take), .shift(shift_en), .d(bus.op_a), .q(sa)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk(clk), .reset(reset), .load(take), .shift(shift_en), .d(bus.op_b), .q(sb)
  );

  // Outputs are registered from the state being entered. Each output
  // therefore describes the current state, with no path from start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      clear_q <= 1'b1;  // holds the comparator cleared during reset
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      clear_q <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (take) begin
            state   <= ST_CLEAR;
            cnt     <= CW'(WIDTH - 1);
            clear_q <= 1'b1;
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // No shift on this edge, so the first bit is the loaded MSB.
          state   <= ST_SHIFT;
          valid_q <= 1'b1;
          a_q     <= sa[WIDTH-1];
          b_q     <= sb[WIDTH-1];
          last_q  <= (cnt == '0);
        end
        ST_SHIFT: begin
          if (cnt == '0) begin
            state   <= ST_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt     <= cnt - 1'b1;
            valid_q <= 1'b1;
            a_q     <= sa_shl[WIDTH-1];
            b_q     <= sb_shl[WIDTH-1];
            last_q  <= (cnt == CW'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.cmp_clear = clear_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.bit_valid = valid_q;
  assign bus.last      = last_q;
  assign bus.done      = done_q;
  assign dbg_state     = state;
endmodule
